pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Control-flow stage directly upstream of the nPC register and owner of the PC register.
- Each step it computes the value loaded into nPC (drives nPC_In and Load_Enable) and transfers nPC into PC.
- Implements SPARC delayed-control-transfer semantics: Bicc annul bit, CALL, JMPL/RETT, and trap vectoring through the TBR.
- Holds a small state machine for reset initialisation, annulled delay slots and trap entry.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset; nPC is initialised to RESET_PC+4.
- TT_MISALIGN, 8'h07, trap type raised for a JMPL/RETT target whose bits [1:0] are not zero.

Ports:
- Clock  in  1  system clock; all state updates on the falling edge, matching the nPC register.
- Reset_n  in  1  asynchronous, active-low reset.
- Advance  in  1  pipeline step enable from control unit.
- nPC  in  32  current output of the nPC register.
- Op  in  3  000 SEQ, 001 BRANCH, 010 CALL, 011 JMPL, 100 RETT; other codes behave as SEQ.
- Cond_True  in  1  branch condition evaluated true.
- Annul_Bit  in  1  "a" field of Bicc.
- Branch_Always  in  1  branch is BA.
- Disp22  in  22  Bicc word displacement.
- Disp30  in  30  CALL word displacement.
- Jmp_Target  in  32  ALU result rs1+rs2/simm13 for JMPL/RETT.
- Trap_Req  in  1  external or exception trap request.
- Trap_Type  in  8  TT for Trap_Req.
- TBR_Base  in  20  TBR trap base address, bits [31:12].
- PC  out  32  current PC.
- nPC_Next  out  32  to nPC register nPC_In.
- nPC_Load  out  1  to nPC register Load_Enable.
- Annul_Slot  out  1  instruction at PC is annulled; decode must squash it.
- Trap_Ack  out  1  high for the single TRAP_ENTRY cycle.
- Saved_PC  out  32  PC captured at trap, for r17.
- Saved_nPC  out  32  nPC captured at trap, for r18.

Behaviour:
- States: INIT, RUN, ANNUL, TRAP_ENTRY.
- Reset (async, any state, including mid-trap): state=INIT, PC=RESET_PC, Saved_PC=0, Saved_nPC=0. Outputs during reset: Annul_Slot=0, Trap_Ack=0.
- INIT: nPC_Load=1 and nPC_Next=RESET_PC+4, regardless of Advance. At the next edge go to RUN; PC is unchanged.
- RUN or ANNUL with Advance=0: nPC_Load=0 and no register changes.
- Advance=1 in RUN, no trap: nPC_Load=1 and PC<=nPC at the edge. nPC_Next is combinational:
  - SEQ: nPC+4.
  - BRANCH taken: PC + (sext(Disp22)<<2). Not taken: nPC+4.
  - CALL: PC + (Disp30<<2).
  - JMPL/RETT: Jmp_Target.
- Address arithmetic is modulo 2^32; wrap-around is silent.
- Annul rule for BRANCH: the delay slot is annulled if Annul_Bit && (!Cond_True || Branch_Always). When annulled, go to ANNUL.
- ANNUL: Annul_Slot=1. Op and Trap_Req are ignored; sequencing is treated as SEQ. On Advance go to RUN.
- Trap priority: Trap_Req > misaligned JMPL/RETT target > Op.
  - Effective TT is Trap_Type, or TT_MISALIGN for a misaligned target.
  - Vector = {TBR_Base, TT, 4'b0000}.
- Trap taken in RUN with Advance=1:
  - At the edge: Saved_PC<=PC, Saved_nPC<=nPC, PC<=Vector. Go to TRAP_ENTRY.
  - During the trap cycle: nPC_Load=1, nPC_Next=Vector+4.
- TRAP_ENTRY: Trap_Ack=1, nPC_Load=0, Advance and Trap_Req are ignored. Go to RUN at the next edge.
- Trap_Req arriving during INIT, TRAP_ENTRY or ANNUL is not latched; the requester holds it.

Test Plan:
- Reset pulse, then 3 Advance cycles -> INIT drives nPC_Next=0x4 with load; PC sequence is 0x0, 0x4, 0x8, 0xC.
- PC=0x100, nPC=0x104, BRANCH, Cond_True=1, a=0, Disp22=0x10 -> nPC_Next=0x140, PC becomes 0x104, Annul_Slot=0.
- PC=0x100, BRANCH, Cond_True=0, a=1 -> nPC_Next=0x108, next cycle Annul_Slot=1. Repeat with BA, a=1, Disp22=0x10 -> target 0x140, slot annulled.
- JMPL with Jmp_Target=0x2002, TBR_Base=20'h40000 -> Saved_PC/Saved_nPC captured, PC=0x4000_0070, then nPC_Next=0x4000_0074, Trap_Ack=1 for one cycle.
- Trap_Req with TT=0x11 simultaneous with CALL -> trap wins, PC=0x4000_0110. Trap_Req during ANNUL -> ignored.
- Assert Reset_n low in TRAP_ENTRY between clock edges -> PC=0 and Trap_Ack=0 immediately, then INIT.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: bundles the step controls, operand fields and PC/nPC
// results exchanged between the control unit and the PC sequencer.
//
// Handshake: there is no valid/ready pair. Advance is a one-sided step
// enable. When it is sampled high at a falling clock edge, one pipeline step
// completes. When it is low, the sequencer holds its state. The exceptions
// are INIT and TRAP_ENTRY, which always complete in a single edge.
//
// Modports:
//   slave  - the sequencer (consumes Advance/operands, drives PC/nPC_Next...)
//   master - the control unit / testbench side
interface pc_sequencer_if;
    logic        Advance;
    logic [31:0] nPC;
    logic [2:0]  Op;
    logic        Cond_True;
    logic        Annul_Bit;
    logic        Branch_Always;
    logic [21:0] Disp22;
    logic [29:0] Disp30;
    logic [31:0] Jmp_Target;
    logic        Trap_Req;
    logic [7:0]  Trap_Type;
    logic [19:0] TBR_Base;
    logic [31:0] PC;
    logic [31:0] nPC_Next;
    logic        nPC_Load;
    logic        Annul_Slot;
    logic        Trap_Ack;
    logic [31:0] Saved_PC;
    logic [31:0] Saved_nPC;
    logic [1:0]  dbg_state;

    modport slave (
        input  Advance, nPC, Op, Cond_True, Annul_Bit, Branch_Always,
               Disp22, Disp30, Jmp_Target, Trap_Req, Trap_Type, TBR_Base,
        output PC, nPC_Next, nPC_Load, Annul_Slot, Trap_Ack,
               Saved_PC, Saved_nPC, dbg_state
    );

    modport master (
        output Advance, nPC, Op, Cond_True, Annul_Bit, Branch_Always,
               Disp22, Disp30, Jmp_Target, Trap_Req, Trap_Type, TBR_Base,
        input  PC, nPC_Next, nPC_Load, Annul_Slot, Trap_Ack,
               Saved_PC, Saved_nPC, dbg_state
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC register and computes the next value of the
// external nPC register. It implements SPARC delayed control transfer:
// branches with the annul bit, CALL, JMPL/RETT, and trap vectoring
// through the TBR.
//
// Ports:
//   Clock    - system clock; all state updates on the falling edge
//   Reset_n  - asynchronous active-low reset
//   bus      - pc_sequencer_if.slave:
//              in : Advance, nPC, Op, Cond_True, Annul_Bit, Branch_Always,
//                   Disp22, Disp30, Jmp_Target, Trap_Req, Trap_Type, TBR_Base
//              out: PC, nPC_Next, nPC_Load, Annul_Slot, Trap_Ack,
//                   Saved_PC, Saved_nPC, dbg_state (FSM state encoding)
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [7:0]  TT_MISALIGN = 8'h07
) (
    input logic           Clock,
    input logic           Reset_n,
    pc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        INIT       = 2'd0,
        RUN        = 2'd1,
        ANNUL      = 2'd2,
        TRAP_ENTRY = 2'd3
    } state_t;

    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_CALL   = 3'b010;
    localparam logic [2:0] OP_JMPL   = 3'b011;
    localparam logic [2:0] OP_RETT   = 3'b100;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] saved_pc_q;
    logic [31:0] saved_npc_q;
    logic        annul_q;
    logic        ack_q;

    logic        is_branch;
    logic        is_call;
    logic        is_jump;
    logic        misaligned;
    logic        trap_take;
    logic        br_taken;
    logic        br_annul;
    logic [7:0]  eff_tt;
    logic [31:0] vector;
    logic [31:0] br_off;
    logic [31:0] call_off;
    logic [31:0] npc_next;
    logic        npc_load;

    assign is_branch = (bus.Op == OP_BRANCH);
    assign is_call   = (bus.Op == OP_CALL);
    assign is_jump   = (bus.Op == OP_JMPL) || (bus.Op == OP_RETT);

    // An alignment fault is only meaningful for a jump that is actually
    // being executed, so it is qualified with the op.
    assign misaligned = is_jump && (bus.Jmp_Target[1:0] != 2'b00);
    assign trap_take  = (state == RUN) && bus.Advance && (bus.Trap_Req || misaligned);

    // An external trap request outranks an alignment fault from the same step.
    assign eff_tt = bus.Trap_Req ? bus.Trap_Type : TT_MISALIGN;
    assign vector = {bus.TBR_Base, eff_tt, 4'b0000};

    // BA counts as taken even if the condition logic reports false.
    assign br_taken = bus.Cond_True || bus.Branch_Always;
    // Annul the slot of an untaken conditional branch, or of BA ("ba,a").
    assign br_annul = bus.Annul_Bit && (!bus.Cond_True || bus.Branch_Always);

    assign br_off   = {{8{bus.Disp22[21]}}, bus.Disp22, 2'b00};
    assign call_off = {bus.Disp30, 2'b00};

    always_comb begin
        npc_next = bus.nPC + 32'd4;
        npc_load = 1'b0;
        case (state)
            INIT: begin
                npc_next = RESET_PC + 32'd4;
                npc_load = 1'b1;
            end
            RUN: begin
                if (bus.Advance) begin
                    npc_load = 1'b1;
                    if (trap_take) begin
                        // nPC loads Vector+4 on the same edge that PC loads Vector.
                        npc_next = vector + 32'd4;
                    end else if (is_branch) begin
                        if (br_taken) npc_next = pc_q + br_off;
                    end else if (is_call) begin
                        npc_next = pc_q + call_off;
                    end else if (is_jump) begin
                        npc_next = bus.Jmp_Target;
                    end
                end
            end
            ANNUL: begin
                // The squashed slot always sequences as SEQ.
                npc_load = bus.Advance;
            end
            TRAP_ENTRY: begin
                // nPC already holds the vector successor; this value is not loaded.
                npc_next = pc_q + 32'd4;
            end
            default: begin
                npc_load = 1'b0;
            end
        endcase
    end

    always_ff @(negedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= INIT;
            pc_q        <= RESET_PC;
            saved_pc_q  <= 32'h0;
            saved_npc_q <= 32'h0;
            annul_q     <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    state <= RUN;
                end
                RUN: begin
                    if (bus.Advance) begin
                        if (trap_take) begin
                            saved_pc_q  <= pc_q;
                            saved_npc_q <= bus.nPC;
                            pc_q        <= vector;
                            state       <= TRAP_ENTRY;
                            ack_q       <= 1'b1;
                        end else begin
                            pc_q <= bus.nPC;
                            if (is_branch && br_annul) begin
                                state   <= ANNUL;
                                annul_q <= 1'b1;
                            end
                        end
                    end
                end
                ANNUL: begin
                    if (bus.Advance) begin
                        pc_q    <= bus.nPC;
                        state   <= RUN;
                        annul_q <= 1'b0;
                    end
                end
                TRAP_ENTRY: begin
                    state <= RUN;
                    ack_q <= 1'b0;
                end
                default: begin
                    state   <= INIT;
                    annul_q <= 1'b0;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PC         = pc_q;
    assign bus.nPC_Next   = npc_next;
    assign bus.nPC_Load   = npc_load;
    assign bus.Annul_Slot = annul_q;
    assign bus.Trap_Ack   = ack_q;
    assign bus.Saved_PC   = saved_pc_q;
    assign bus.Saved_nPC  = saved_npc_q;
    assign bus.dbg_state  = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed test of pc_sequencer. The bench holds a model
// of the external nPC register, which is fed from nPC_Next/nPC_Load. Inputs
// change one time unit after each falling edge. Comparisons happen before
// the next falling edge for combinational outputs, and after it for
// registered state.
module tb_pc_sequencer;

    localparam logic [2:0] SEQ  = 3'b000;
    localparam logic [2:0] BR   = 3'b001;
    localparam logic [2:0] CALL = 3'b010;
    localparam logic [2:0] JMPL = 3'b011;
    localparam logic [2:0] RETT = 3'b100;

    localparam logic [1:0] S_INIT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_ANNUL = 2'd2;
    localparam logic [1:0] S_TRAP  = 2'd3;

    logic        Clock;
    logic        Reset_n;
    logic [31:0] npc_reg;
    int          n_cmp;
    int          n_err;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_PC   (32'h0000_0000),
        .TT_MISALIGN(8'h07)
    ) dut (
        .Clock  (Clock),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    // Clock / reset block.
    initial Clock = 1'b1;
    always #5 Clock = ~Clock;

    // External nPC register, updated on the same falling edge as the DUT.
    always @(negedge Clock or negedge Reset_n) begin
        if (!Reset_n) npc_reg <= 32'h0;
        else if (bus.nPC_Load) npc_reg <= bus.nPC_Next;
    end
    assign bus.nPC = npc_reg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic adv, input logic [2:0] op, input logic ct,
                       input logic ab, input logic ba, input logic [21:0] d22,
                       input logic [29:0] d30, input logic [31:0] jt,
                       input logic tr, input logic [7:0] tt);
        bus.Advance       = adv;
        bus.Op            = op;
        bus.Cond_True     = ct;
        bus.Annul_Bit     = ab;
        bus.Branch_Always = ba;
        bus.Disp22        = d22;
        bus.Disp30        = d30;
        bus.Jmp_Target    = jt;
        bus.Trap_Req      = tr;
        bus.Trap_Type     = tt;
        #1;
    endtask

    task automatic tick();
        @(negedge Clock);
        #1;
    endtask

    // From any RUN state: jump to 0x100 and take the delay slot, leaving
    // PC=0x100, nPC=0x104.
    task automatic goto_100(input logic [2:0] jop);
        drv(1, jop, 0, 0, 0, 22'h0, 30'h0, 32'h100, 0, 8'h0);
        chk("goto_jump_next", bus.nPC_Next, 32'h100);
        tick();
        drv(1, SEQ, 0, 0, 0, 22'h0, 30'h0, 32'h0, 0, 8'h0);
        tick();
        chk("goto_pc", bus.PC, 32'h100);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        Reset_n = 1'b0;
        bus.TBR_Base = 20'h40000;
        drv(0, SEQ, 0, 0, 0, 22'h0, 30'h0, 32'h0, 0, 8'h0);

        // Reset state.
        chk("rst_pc", bus.PC, 32'h0);
        chk("rst_annul", 32'(bus.Annul_Slot), 32'h0);
        chk("rst_ack", 32'(bus.Trap_Ack), 32'h0);
        chk("rst_saved_pc", bus.Saved_PC, 32'h0);
        chk("rst_saved_npc", bus.Saved_nPC, 32'h0);
        chk("rst_state", 32'(bus.dbg_state), 32'(S_INIT));

        @(negedge Clock);
        #2;
        Reset_n = 1'b1;
        #1;

        // INIT loads nPC=4 regardless of Advance; PC stays at 0.
        drv(1, SEQ, 0, 0, 0, 22'h0, 30'h0, 32'h0, 0, 8'h0);
        chk("init_load", 32'(bus.nPC_Load), 32'h1);
        chk("init_next", bus.nPC_Next, 32'h4);
        tick();
        chk("init_pc", bus.PC, 32'h0);
        chk("init_to_run", 32'(bus.dbg_state), 32'(S_RUN));

        // Three sequential steps; an undefined op code behaves as SEQ.
        drv(1, SEQ, 0, 0, 0, 22'h0, 30'h0, 32'h0, 0, 8'h0);
        chk("seq1_next", bus.nPC_Next, 32'h8);
        tick();
        chk("seq1_pc", bus.PC, 32'h4);
        drv(1, 3'b111, 1, 1, 1, 22'h10, 30'h10, 32'h3, 0, 8'h0);
        chk("op7_next", bus.nPC_Next, 32'hC);
        tick();
        chk("seq2_pc", bus.PC, 32'h8);
        drv(1, SEQ, 0, 0, 0, 22'h0, 30'h0, 32'h0, 0, 8'h0);
        tick();
        chk("seq3_pc", bus.PC, 32'hC);

        // Stall: no load, no PC change.
        drv(0, SEQ, 0, 0, 0, 22'h0, 30'h0, 32'h0, 0, 8'h0);
        chk("stall_load", 32'(bus.nPC_Load), 32'h0);
        tick();
        chk("stall_pc", bus.PC, 32'hC);

        // CALL from PC=0xC: 0xC + 0x3D*4 = 0x100.
        drv(1, CALL, 0, 0, 0, 22'h0, 30'h3D, 32'h0, 0, 8'h0);
        chk("call_next", bus.nPC_Next, 32'h100);
        tick();
        chk("call_pc", bus.PC, 32'h10);
        drv(1, SEQ, 0, 0, 0, 22'h0, 30'h0, 32'h0, 0, 8'h0);
        tick();
        chk("call_slot_pc", bus.PC, 32'h100);

        // Taken branch, no annul.
        drv(1, BR, 1, 0, 0, 22'h10, 30'h0, 32'h0, 0, 8'h0);
        chk("br_taken_next", bus.nPC_Next, 32'h140);
        chk("br_taken_load", 32'(bus.nPC_Load), 32'h1);
        tick();
        chk("br_taken_pc", bus.PC, 32'h104);
        chk("br_taken_annul", 32'(bus.Annul_Slot), 32'h0);

        // Untaken branch with a=1: slot annulled; trap and op ignored in ANNUL.
        goto_100(JMPL);
        drv(1, BR, 0, 1, 0, 22'h10, 30'h0, 32'h0, 0, 8'h0);
        chk("br_nt_next", bus.nPC_Next, 32'h108);
        tick();
        chk("br_nt_pc", bus.PC, 32'h104);
        chk("br_nt_annul", 32'(bus.Annul_Slot), 32'h1);
        chk("br_nt_state", 32'(bus.dbg_state), 32'(S_ANNUL));
        drv(0, CALL, 0, 0, 0, 22'h0, 30'h55, 32'h0, 1, 8'h11);
        chk("annul_stall_load", 32'(bus.nPC_Load), 32'h0);
        tick();
        chk("annul_stall_slot", 32'(bus.Annul_Slot), 32'h1);
        drv(1, CALL, 0, 0, 0, 22'h0, 30'h55, 32'h0, 1, 8'h11);
        chk("annul_seq_next", bus.nPC_Next, 32'h10C);
        tick();
        chk("annul_exit_pc", bus.PC, 32'h108);
        chk("annul_exit_slot", 32'(bus.Annul_Slot), 32'h0);
        chk("annul_no_trap", 32'(bus.Trap_Ack), 32'h0);
        chk("annul_no_save", bus.Saved_PC, 32'h0);

        // BA with a=1: target 0x140, slot annulled.
        goto_100(RETT);
        drv(1, BR, 1, 1, 1, 22'h10, 30'h0, 32'h0, 0, 8'h0);
        chk("ba_next", bus.nPC_Next, 32'h140);
        tick();
        chk("ba_annul", 32'(bus.Annul_Slot), 32'h1);
        drv(1, SEQ, 0, 0, 0, 22'h0, 30'h0, 32'h0, 0, 8'h0);
        chk("ba_slot_next", bus.nPC_Next, 32'h144);
        tick();
        chk("ba_target_pc", bus.PC, 32'h140);

        // Backward branch: 0x140 + sext(0x3FFFF0)*4 = 0x100.
        drv(1, BR, 1, 0, 0, 22'h3FFFF0, 30'h0, 32'h0, 0, 8'h0);
        chk("br_back_next", bus.nPC_Next, 32'h100);
        tick();
        chk("br_back_pc", bus.PC, 32'h144);

        // Misaligned JMPL traps with TT 0x07.
        drv(1, JMPL, 0, 0, 0, 22'h0, 30'h0, 32'h2002, 0, 8'h0);
        chk("mis_next", bus.nPC_Next, 32'h4000_0074);
        chk("mis_load", 32'(bus.nPC_Load), 32'h1);
        tick();
        chk("mis_pc", bus.PC, 32'h4000_0070);
        chk("mis_saved_pc", bus.Saved_PC, 32'h144);
        chk("mis_saved_npc", bus.Saved_nPC, 32'h100);
        chk("mis_ack", 32'(bus.Trap_Ack), 32'h1);
        drv(1, JMPL, 0, 0, 0, 22'h0, 30'h0, 32'h2002, 1, 8'h22);
        chk("trap_entry_load", 32'(bus.nPC_Load), 32'h0);
        tick();
        chk("trap_exit_ack", 32'(bus.Trap_Ack), 32'h0);
        chk("trap_exit_pc", bus.PC, 32'h4000_0070);
        chk("trap_exit_state", 32'(bus.dbg_state), 32'(S_RUN));

        // Trap_Req beats a simultaneous CALL.
        drv(1, CALL, 0, 0, 0, 22'h0, 30'h5, 32'h0, 1, 8'h11);
        chk("req_next", bus.nPC_Next, 32'h4000_0114);
        tick();
        chk("req_pc", bus.PC, 32'h4000_0110);
        chk("req_saved_pc", bus.Saved_PC, 32'h4000_0070);
        chk("req_saved_npc", bus.Saved_nPC, 32'h4000_0074);
        chk("req_state", 32'(bus.dbg_state), 32'(S_TRAP));

        // Async reset in the middle of TRAP_ENTRY.
        #2;
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_pc", bus.PC, 32'h0);
        chk("mid_rst_ack", 32'(bus.Trap_Ack), 32'h0);
        chk("mid_rst_saved", bus.Saved_PC, 32'h0);
        chk("mid_rst_state", 32'(bus.dbg_state), 32'(S_INIT));
        tick();
        Reset_n = 1'b1;
        #1;
        chk("post_rst_load", 32'(bus.nPC_Load), 32'h1);
        chk("post_rst_next", bus.nPC_Next, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
